lsu_dmem_master: RTL and testbench
==================================

Name: lsu_dmem_master

Overview:
Load/store initiator that drives a word-organised, byte-unmasked data memory: word index, single write strobe, 32-bit write data, combinational 32-bit read data.
Accepts one RV32 load/store request at a time from the execute stage and performs the memory access.
Builds LB/LH/LBU/LHU from word reads, and SB/SH as read-modify-write sequences.
Returns load data and completion on a single-cycle response strobe.

Parameters:
ADDR_W, 16, width of the memory word-index port (word index = byte address [ADDR_W+1:2])
DEPTH_WORDS, 2048, number of words in the attached memory; index values >= DEPTH_WORDS wrap modulo DEPTH_WORDS

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous active-high reset
i_req_valid  input  1  request present
o_req_ready  output  1  high only in IDLE; request accepted when valid && ready
i_req_we  input  1  1 = store, 0 = load
i_req_funct3  input  3  RV32 width/sign code
i_req_addr  input  32  byte address
i_req_wdata  input  32  store data, right-aligned
o_rsp_valid  output  1  one-cycle completion strobe
o_rsp_rdata  output  32  load result, sign/zero-extended; 0 for stores
o_rsp_misalign  output  1  qualified by o_rsp_valid
o_lsu_addr  output  ADDR_W  memory word index
o_wren  output  1  memory write strobe
o_wdata  output  32  memory write data
i_data_dmem  input  32  memory read data, combinational from o_lsu_addr

Behaviour:
- Reset: asynchronous, active-high. Registers and outputs go to the following values:
  - state = IDLE
  - o_req_ready = 1
  - o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_misalign = 0
  - o_lsu_addr = 0, o_wren = 0, o_wdata = 0
- Reset mid-sequence: the sequence is aborted and no write is issued afterwards. A write already committed on an earlier edge stays in memory.
- funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- funct3 for stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 code is executed as LW/SW.
- Acceptance: on valid && ready, the request is latched (we, funct3, addr, wdata) and the FSM leaves IDLE.
- FSM states and transitions:
  - IDLE -> LOAD (load) | WRITE (SW) | RMW_RD (SB/SH) | RESP (misaligned, see Optional Feature).
  - LOAD: o_lsu_addr = word index; the byte/half lane is selected by addr[1:0] and extended, then registered into o_rsp_rdata. -> RESP.
  - RMW_RD: o_lsu_addr = word index. i_data_dmem is captured and the store lane is replaced:
    - SB: byte lane addr[1:0] ← wdata[7:0].
    - SH: half lane addr[1] ← wdata[15:0].
    - Result goes to the merge register. -> WRITE.
  - WRITE: o_lsu_addr = word index, o_wren = 1, o_wdata = full wdata (SW) or merge register (SB/SH), asserted for exactly one cycle. -> RESP.
  - RESP: o_rsp_valid = 1 for exactly one cycle. -> IDLE.
- Output defaults: o_wren = 0 in every state except WRITE. o_req_ready = 0 outside IDLE; requests are ignored while busy.
- Latency, counted as cycles from the acceptance edge to the o_rsp_valid edge:
  - load: 2
  - SW: 2
  - SB/SH: 3
  - misaligned: 1
- Back-to-back: a new request can be accepted in the cycle after RESP (IDLE). There is no throughput overlap.
- o_rsp_rdata holds its value until the next load completes. Stores load 0 into it.

Optional Feature:
Macro LSU_MISALIGN_EN.
- Defined:
  - Halfword access with addr[0] = 1, or word access with addr[1:0] != 0, goes IDLE -> RESP directly.
  - That response carries o_rsp_misalign = 1 and o_rsp_rdata = 0.
  - No memory write occurs.
- Undefined:
  - Offending low address bits are masked (half: addr[0] forced 0; word: addr[1:0] forced 0) and the access proceeds normally.
  - o_rsp_misalign is tied 0.

Test Plan:
- Reset value check: assert i_rst mid-RMW_RD → all outputs take their reset values immediately; after release, o_req_ready = 1 and memory is unchanged.
- SW, then LW at 0x0000_0010 with data 0xDEAD_BEEF → o_wren for one cycle at index 4; load returns 0xDEADBEEF with o_rsp_valid two cycles after acceptance.
- Word preset to 0x1122_3344, SB 0xAA to addr 0x11 → memory word 0x1122_AA44, rsp three cycles after acceptance. Then:
  - LB 0x11 → 0xFFFF_FFAA
  - LBU 0x11 → 0x0000_00AA
- SH 0x8001 to addr 0x12 over 0x1122_3344 → word 0x8001_3344. Then:
  - LH 0x12 → 0xFFFF_8001
  - LHU 0x12 → 0x0000_8001
- Request held valid while busy → exactly one acceptance per RESP; a second request is accepted in the cycle after o_rsp_valid.
- With LSU_MISALIGN_EN, LW at 0x13 → o_rsp_misalign = 1 one cycle after acceptance, o_wren never asserted. Without it, the same LW reads index 4.

Source files
------------

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: RV32 load/store initiator for a word-organised data memory.
// Sub-word loads are extracted from full-word reads; SB/SH are performed as
// read-modify-write sequences because the memory has no byte enables.
// Optional macro LSU_MISALIGN_EN: misaligned half/word accesses are rejected
// with o_rsp_misalign instead of having their low address bits masked.
module lsu_dmem_master #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 2048
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_misalign,
    output logic [ADDR_W-1:0] o_lsu_addr,
    output logic              o_wren,
    output logic [31:0]       o_wdata,
    input  logic [31:0]       i_data_dmem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    // Unsigned load codes only exist for loads; for stores they fall back to SW.
    function automatic size_t decode_size(input logic we, input logic [2:0] funct3);
        size_t sz;
        sz = SZ_WORD;
        case (funct3)
            3'b000:  sz = SZ_BYTE;
            3'b001:  sz = SZ_HALF;
            3'b100:  sz = we ? SZ_WORD : SZ_BYTE;
            3'b101:  sz = we ? SZ_WORD : SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    state_t            state;
    state_t            state_next;
    logic              accept;
    size_t             in_size;
    size_t             req_size;
    logic              in_misalign;
    logic              resp_zero;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       merge_q;
    logic [ADDR_W-1:0] word_idx;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic              load_signed;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              unused_addr_hi;

    // Address bits above the word-index field never reach the memory.
    assign unused_addr_hi = ^i_req_addr[31:ADDR_W+2];

    assign accept   = i_req_valid && (state == S_IDLE);
    assign in_size  = decode_size(i_req_we, i_req_funct3);
    assign req_size = decode_size(req_we, req_funct3);
    assign word_idx = req_addr[ADDR_W+1:2] % ADDR_W'(DEPTH_WORDS);

`ifdef LSU_MISALIGN_EN
    logic req_misalign;

    assign in_misalign = ((in_size == SZ_HALF) && i_req_addr[0]) ||
                         ((in_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));
    assign resp_zero   = req_we || req_misalign;

    // Remember whether the accepted request was rejected as misaligned.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_misalign <= 1'b0;
        end else if (accept) begin
            req_misalign <= in_misalign;
        end
    end

    // Misalign flag is registered alongside o_rsp_valid so both pulse together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rsp_misalign <= 1'b0;
        end else begin
            o_rsp_misalign <= (state == S_RESP) && req_misalign;
        end
    end
`else
    // Misaligned offsets are simply ignored by the lane selection below.
    assign in_misalign    = 1'b0;
    assign resp_zero      = req_we;
    assign o_rsp_misalign = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the request on acceptance so the inputs are free while busy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_we     <= 1'b0;
            req_funct3 <= 3'b000;
            req_addr   <= '0;
            req_wdata  <= 32'h0;
        end else if (accept) begin
            req_we     <= i_req_we;
            req_funct3 <= i_req_funct3;
            req_addr   <= i_req_addr[ADDR_W+1:0];
            req_wdata  <= i_req_wdata;
        end
    end

    // Extract and extend the addressed lane of the word being read.
    always_comb begin
        load_byte   = i_data_dmem[7:0];
        load_half   = i_data_dmem[15:0];
        load_signed = ~req_funct3[2];
        load_data   = i_data_dmem;
        case (req_addr[1:0])
            2'd1:    load_byte = i_data_dmem[15:8];
            2'd2:    load_byte = i_data_dmem[23:16];
            2'd3:    load_byte = i_data_dmem[31:24];
            default: load_byte = i_data_dmem[7:0];
        endcase
        if (req_addr[1]) begin
            load_half = i_data_dmem[31:16];
        end
        case (req_size)
            SZ_BYTE: load_data = {{24{load_signed & load_byte[7]}}, load_byte};
            SZ_HALF: load_data = {{16{load_signed & load_half[15]}}, load_half};
            default: load_data = i_data_dmem;
        endcase
    end

    // Splice the store lane into the word read back from memory.
    always_comb begin
        merge_data = i_data_dmem;
        if (req_size == SZ_BYTE) begin
            case (req_addr[1:0])
                2'd1:    merge_data[15:8]  = req_wdata[7:0];
                2'd2:    merge_data[23:16] = req_wdata[7:0];
                2'd3:    merge_data[31:24] = req_wdata[7:0];
                default: merge_data[7:0]   = req_wdata[7:0];
            endcase
        end else if (req_size == SZ_HALF) begin
            if (req_addr[1]) begin
                merge_data[31:16] = req_wdata[15:0];
            end else begin
                merge_data[15:0] = req_wdata[15:0];
            end
        end
    end

    // Hold the merged word from RMW_RD for the following WRITE cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            merge_q <= 32'h0;
        end else if (state == S_RMW_RD) begin
            merge_q <= merge_data;
        end
    end

    // Next-state logic and memory-side outputs, idle values first.
    always_comb begin
        state_next  = state;
        o_req_ready = 1'b0;
        o_lsu_addr  = '0;
        o_wren      = 1'b0;
        o_wdata     = 32'h0;
        case (state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (in_misalign) begin
                        state_next = S_RESP;
                    end else if (!i_req_we) begin
                        state_next = S_LOAD;
                    end else if (in_size == SZ_WORD) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                o_lsu_addr = word_idx;
                state_next = S_RESP;
            end
            S_RMW_RD: begin
                o_lsu_addr = word_idx;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                o_lsu_addr = word_idx;
                o_wren     = 1'b1;
                o_wdata    = (req_size == SZ_WORD) ? req_wdata : merge_q;
                state_next = S_RESP;
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Response strobe follows RESP by one edge; load data is kept until the next load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'h0;
        end else begin
            o_rsp_valid <= (state == S_RESP);
            if (state == S_LOAD) begin
                o_rsp_rdata <= load_data;
            end else if ((state == S_RESP) && resp_zero) begin
                o_rsp_rdata <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: self-checking bench for lsu_dmem_master with an attached
// word memory, a table of directed vectors, hand-written corner sequences and
// randomized traffic compared against a behavioural memory model.
// Honours LSU_MISALIGN_EN the same way the design does.
module tb_lsu_dmem_master;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 2048;
    localparam int NVEC   = 14;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_wrens;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_misalign;
    logic [ADDR_W-1:0] lsu_addr;
    logic              wren;
    logic [31:0]       wdata;
    logic [31:0]       dmem_rdata;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        mem_init;
    int          wr_count = 0;

    int checks = 0;
    int errors = 0;

    vec_t        vecs [NVEC];
    logic [31:0] m_rdata, a_rdata, saved_word, held;
    logic        m_mis, a_mis, r_we;
    int          m_lat, m_wrens, m_idx, a_lat, a_wrens, a_idx;
    int          wc_before, acc, pulses, diffs;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;

    lsu_dmem_master #(
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_funct3   (req_funct3),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_misalign (rsp_misalign),
        .o_lsu_addr     (lsu_addr),
        .o_wren         (wren),
        .o_wdata        (wdata),
        .i_data_dmem    (dmem_rdata)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Deterministic power-up content shared by the memory and the model.
    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Word index the memory sees: byte address bits [17:2], wrapped to the depth.
    function automatic int idx_of(input logic [31:0] a);
        return int'(a[ADDR_W+1:2]) % DEPTH;
    endfunction

    // Memory read is combinational from the word index, with wrap-around.
    assign dmem_rdata = mem[int'(lsu_addr) % DEPTH];

    // Memory write port plus a running count of write strobes.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= init_val(i);
            end
        end else if (wren) begin
            mem[int'(lsu_addr) % DEPTH] <= wdata;
            wr_count <= wr_count + 1;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // All externally visible outputs must sit at their reset values.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"},    32'(req_ready),    32'd1);
        checkOutput({tag, "_rspvalid"}, 32'(rsp_valid),    32'd0);
        checkOutput({tag, "_rdata"},    rsp_rdata,         32'd0);
        checkOutput({tag, "_misalign"}, 32'(rsp_misalign), 32'd0);
        checkOutput({tag, "_lsuaddr"},  32'(lsu_addr),     32'd0);
        checkOutput({tag, "_wren"},     32'(wren),         32'd0);
        checkOutput({tag, "_wdata"},    wdata,             32'd0);
    endtask

    // Behavioural model: access size and signedness straight from the RV32
    // code tables, lanes handled with shift/mask arithmetic on a shadow memory.
    task automatic modelAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, output logic [31:0] rdata, output logic mis,
                               output int lat, output int wrens, output int idx);
        int          sz;
        int          off;
        logic        sgn;
        logic [63:0] w, v, m, lane;
        sz  = 4;
        sgn = 1'b0;
        if (we) begin
            if (f3 == 3'b000) sz = 1;
            else if (f3 == 3'b001) sz = 2;
        end else begin
            if (f3 == 3'b000) begin sz = 1; sgn = 1'b1; end
            else if (f3 == 3'b001) begin sz = 2; sgn = 1'b1; end
            else if (f3 == 3'b100) sz = 1;
            else if (f3 == 3'b101) sz = 2;
        end
        off   = int'(addr[1:0]);
        idx   = idx_of(addr);
        mis   = 1'b0;
        rdata = 32'h0;
        wrens = 0;
`ifdef LSU_MISALIGN_EN
        if ((off % sz) != 0) mis = 1'b1;
`endif
        if (mis) begin
            lat = 1;
            return;
        end
        off  = off - (off % sz);
        w    = {32'h0, ref_mem[idx]};
        m    = (64'd1 << (8 * sz)) - 64'd1;
        lane = m << (8 * off);
        if (!we) begin
            v = (w >> (8 * off)) & m;
            if (sgn && v[8*sz-1]) v = v | ~m;
            rdata = v[31:0];
            lat   = 2;
        end else begin
            v = (w & ~lane) | (({32'h0, wd} << (8 * off)) & lane);
            ref_mem[idx] = v[31:0];
            lat   = (sz == 4) ? 2 : 3;
            wrens = 1;
        end
    endtask

    // Drives one request, waits (bounded) for the response and reports what happened.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic [31:0] rdata, output logic mis,
                                 output int lat, output int wrens, output int first_idx);
        int guard;
        int wr_before;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
        wr_before = wr_count;
        @(negedge clk);
        req_valid = 1'b0;
        first_idx = int'(lsu_addr);
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) checkOutput("rsp_timeout", 32'd0, 32'd1);
        rdata = rsp_rdata;
        mis   = rsp_misalign;
        wrens = wr_count - wr_before;
    endtask

    // Run-away guard so the bench always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        rst        = 1'b1;
        mem_init   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

        vecs[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 2, 1};
        vecs[1]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 2, 0};
        vecs[2]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 2, 1};
        vecs[3]  = '{1'b1, 3'b000, 32'h0000_0011, 32'h0000_00AA, 32'h0000_0000, 3, 1};
        vecs[4]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h1122_AA44, 2, 0};
        vecs[5]  = '{1'b0, 3'b000, 32'h0000_0011, 32'h0,         32'hFFFF_FFAA, 2, 0};
        vecs[6]  = '{1'b0, 3'b100, 32'h0000_0011, 32'h0,         32'h0000_00AA, 2, 0};
        vecs[7]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 2, 1};
        vecs[8]  = '{1'b1, 3'b001, 32'h0000_0012, 32'h0000_8001, 32'h0000_0000, 3, 1};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h8001_3344, 2, 0};
        vecs[10] = '{1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'hFFFF_8001, 2, 0};
        vecs[11] = '{1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'h0000_8001, 2, 0};
        vecs[12] = '{1'b1, 3'b100, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0000, 2, 1};
        vecs[13] = '{1'b0, 3'b111, 32'h0000_0020, 32'h0,         32'hCAFE_F00D, 2, 0};

        @(negedge clk);
        mem_init = 1'b0;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of an SB read-modify-write must abort it cleanly.
        saved_word = mem[4];
        wc_before  = wr_count;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0011;
        req_wdata  = 32'h0000_0055;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rmw_rd_index", 32'(lsu_addr), 32'd4);
        rst = 1'b1;
        #1;
        checkResetOutputs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_ready_after", 32'(req_ready), 32'd1);
        checkOutput("midrst_mem_kept", mem[4], saved_word);
        checkOutput("midrst_no_write", 32'(wr_count - wc_before), 32'd0);

        // Directed vectors.
        for (int v = 0; v < NVEC; v++) begin
            modelAccess(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].wdata, m_rdata, m_mis, m_lat, m_wrens, m_idx);
            applyStimulus(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].wdata, a_rdata, a_mis, a_lat, a_wrens, a_idx);
            checkOutput($sformatf("vec%0d_rdata", v), a_rdata, vecs[v].exp_rdata);
            checkOutput($sformatf("vec%0d_latency", v), 32'(a_lat), 32'(vecs[v].exp_lat));
            checkOutput($sformatf("vec%0d_wrens", v), 32'(a_wrens), 32'(vecs[v].exp_wrens));
            checkOutput($sformatf("vec%0d_index", v), 32'(a_idx), 32'(idx_of(vecs[v].addr)));
            checkOutput($sformatf("vec%0d_misalign", v), 32'(a_mis), 32'd0);
        end

        // Request held valid: one acceptance per response, period of three cycles.
        @(negedge clk);
        wc_before  = wr_count;
        acc        = 0;
        pulses     = 0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0010;
        for (int c = 0; c < 12; c++) begin
            if (req_ready) acc++;
            if (rsp_valid) begin
                pulses++;
                checkOutput($sformatf("b2b_ready_with_rsp%0d", pulses), 32'(req_ready), 32'd1);
                checkOutput($sformatf("b2b_rdata%0d", pulses), rsp_rdata, 32'h8001_3344);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("b2b_accepts", 32'(acc), 32'd4);
        checkOutput("b2b_pulses", 32'(pulses), 32'd3);
        checkOutput("b2b_last_rsp", 32'(rsp_valid), 32'd1);
        checkOutput("b2b_no_write", 32'(wr_count - wc_before), 32'd0);

        // LW to a misaligned byte address, then confirm the load result is held.
        modelAccess(1'b0, 3'b010, 32'h0000_0013, 32'h0, m_rdata, m_mis, m_lat, m_wrens, m_idx);
        applyStimulus(1'b0, 3'b010, 32'h0000_0013, 32'h0, a_rdata, a_mis, a_lat, a_wrens, a_idx);
`ifdef LSU_MISALIGN_EN
        checkOutput("mis_lw_flag", 32'(a_mis), 32'd1);
        checkOutput("mis_lw_latency", 32'(a_lat), 32'd1);
        checkOutput("mis_lw_rdata", a_rdata, 32'h0);
`else
        checkOutput("mis_lw_flag", 32'(a_mis), 32'd0);
        checkOutput("mis_lw_latency", 32'(a_lat), 32'd2);
        checkOutput("mis_lw_rdata", a_rdata, 32'h8001_3344);
        checkOutput("mis_lw_index", 32'(a_idx), 32'd4);
`endif
        checkOutput("mis_lw_wrens", 32'(a_wrens), 32'd0);
        held = a_rdata;
        repeat (3) @(negedge clk);
        checkOutput("rdata_held", rsp_rdata, held);

        // Randomized traffic against the behavioural model.
        for (int n = 0; n < 300; n++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_f3    = 3'($urandom_range(0, 7));
            r_addr  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 127));
            r_wdata = $urandom();
            modelAccess(r_we, r_f3, r_addr, r_wdata, m_rdata, m_mis, m_lat, m_wrens, m_idx);
            applyStimulus(r_we, r_f3, r_addr, r_wdata, a_rdata, a_mis, a_lat, a_wrens, a_idx);
            checkOutput($sformatf("rnd%0d_rdata", n), a_rdata, m_rdata);
            checkOutput($sformatf("rnd%0d_misalign", n), 32'(a_mis), 32'(m_mis));
            checkOutput($sformatf("rnd%0d_latency", n), 32'(a_lat), 32'(m_lat));
            checkOutput($sformatf("rnd%0d_wrens", n), 32'(a_wrens), 32'(m_wrens));
            if (!m_mis) checkOutput($sformatf("rnd%0d_index", n), 32'(a_idx), 32'(m_idx));
        end

        // Whole-memory comparison with the shadow copy.
        @(negedge clk);
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        checkOutput("mem_sweep_diffs", 32'(diffs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
